crc_misr_param: RTL and testbench
=================================

CRC_MISR_PARAM -- requirements
Module: crc_misr_param

Interface
REQ-001 Parameter WIDTH, default 32: signature and data width in bits, legal range 8..64.
REQ-002 Parameter POLY, default 32'h00010811: feedback taps for x^32+x^16+x^11+x^4+1, one bit per register stage; bit i set means stage i receives feedback.
REQ-003 Parameter LEN_W, default 16: width of the word-count input.
REQ-004 Port CLK, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port RESET, input, 1: asynchronous, active-low reset.
REQ-006 Ports TM1, TM0, inputs, 1 each: mode select {TM1,TM0}. 00 = NORMAL, 01 = HOLD, 10 = SHIFT, 11 = LOAD.
REQ-007 Port START, input, 1: begin a signature run.
REQ-008 Port LEN, input, LEN_W: number of words to compress, sampled on START.
REQ-009 Port DIN_VALID, input, 1: DIN is presented this cycle.
REQ-010 Port DIN, input, WIDTH: parallel data word.
REQ-011 Port SEED, input, WIDTH: initial signature.
REQ-012 Port GOLDEN, input, WIDTH: expected final signature.
REQ-013 Port SCAN_IN, input, 1: serial input used in SHIFT mode.
REQ-014 Port SIG, output, WIDTH: current signature register.
REQ-015 Port SCAN_OUT, output, 1: equals SIG[WIDTH-1] in every mode.
REQ-016 Port BUSY, output, 1: FSM is in RUN.
REQ-017 Port DONE, output, 1: FSM is in DONE.
REQ-018 Port PASS, output, 1: registered compare result of the last run.

Function
REQ-019 Compress step: f = SIG[WIDTH-1]; next[0] = DIN[0]^f; next[i] = SIG[i-1]^DIN[i]^(POLY[i]&f) for i ≥ 1.
REQ-020 FSM states: IDLE, RUN, DONE; the FSM advances only in NORMAL mode and holds its state in all other modes.
REQ-021 IDLE or DONE, with START=1 in NORMAL: SIG<=SEED, count<=LEN, PASS<=0; next state RUN if LEN≠0, else DONE with PASS<=(SEED==GOLDEN).
REQ-022 RUN, with DIN_VALID=1 in NORMAL: SIG<=compress step; count decrements by 1.
REQ-023 RUN, with DIN_VALID=1 and count=1: next state DONE and PASS<=(compress result==GOLDEN); DONE and PASS are valid the cycle after the last word.
REQ-024 RUN, with DIN_VALID=0: SIG and count hold.
REQ-025 START in RUN is ignored.
REQ-026 DONE persists, with SIG and PASS stable, until START.
REQ-027 HOLD mode: SIG, count, state and PASS are all unchanged.
REQ-028 SHIFT mode: SIG<={SIG[WIDTH-2:0],SCAN_IN}; DIN is ignored.
REQ-029 LOAD mode: SIG<=SEED; count, state and PASS are unchanged.
REQ-030 A mode change mid-RUN freezes the run; the run resumes when the mode returns to NORMAL.
REQ-031 The counter never wraps: count=0 occurs only in IDLE or DONE.

Reset
REQ-032 RESET=0, asynchronously and at any time including mid-RUN: SIG=0, count=0, state=IDLE, PASS=0, BUSY=0, DONE=0, SCAN_OUT=0.
REQ-033 The first update after RESET rises occurs on the next CLK edge; the deassertion edge needs no synchronisation beyond the codebase reset synchroniser.

Structure
REQ-034 Shared package misr_pkg holds: mode enum (NORMAL, HOLD, SHIFT, LOAD), state enum (IDLE, RUN, DONE), and constant DEFAULT_POLY_32 = 32'h00010811.
REQ-035 The compress step is one combinational sub-module misr_next, parametrised by WIDTH and POLY, instantiated once.
REQ-036 All outputs are driven directly from registers or from SIG[WIDTH-1]; there are no combinational paths from inputs to outputs.

Verification
REQ-037 LOAD SEED=32'h80000000, then START with LEN=1 and DIN=0 -> SIG=32'h00010811; with GOLDEN=32'h00010811, DONE=1 and PASS=1 the next cycle.
REQ-038 START with SEED=0, LEN=0, GOLDEN=0 -> DONE=1 and PASS=1 one cycle later; BUSY is never 1.
REQ-039 LOAD 32'hA5A5A5A5, then SHIFT for 32 cycles with SCAN_IN=0 -> SCAN_OUT sequence 1,0,1,0,0,1,0,1,... and final SIG=0.
REQ-040 RUN with LEN=4 and DIN_VALID gapped 1,0,1,0,1,1 -> DONE on the cycle after the 4th valid word; SIG matches the reference model.
REQ-041 RESET=0 pulsed mid-RUN -> immediate SIG=0, BUSY=0, PASS=0; a subsequent START runs normally.
REQ-042 HOLD asserted for 3 cycles mid-RUN while DIN toggles -> SIG unchanged during HOLD; the final signature is identical to an uninterrupted run.

Source files
------------

// File: rtl/misr_pkg.sv
// ============================================================================
// Module      : misr_pkg
// Description : Shared mode/state encodings and default polynomial for the MISR.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package misr_pkg;

  localparam logic [31:0] DEFAULT_POLY_32 = 32'h00010811;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'b00,
    MODE_HOLD   = 2'b01,
    MODE_SHIFT  = 2'b10,
    MODE_LOAD   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

`default_nettype wire

// File: rtl/misr_next.sv
// ============================================================================
// Module      : misr_next
// Description : One parallel compression step of the multiple-input signature register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module misr_next #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(32'h00010811)
) (
  input  logic [WIDTH-1:0] i_sig,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_next
);

  // Stage 0 always takes the feedback bit, whatever POLY[0] holds.
  localparam logic [WIDTH-1:0] c_taps = {POLY[WIDTH-1:1], 1'b1};

  logic w_fb;

  assign w_fb   = i_sig[WIDTH-1];
  assign o_next = {i_sig[WIDTH-2:0], 1'b0} ^ i_din ^ (c_taps & {WIDTH{w_fb}});

endmodule

`default_nettype wire

// File: rtl/crc_misr_param.sv
// ============================================================================
// Module      : crc_misr_param
// Description : Parameterised MISR with run-length FSM, scan/load test modes and golden compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc_misr_param
  import misr_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEFAULT_POLY_32),
  parameter int               LEN_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             TM1,
  input  logic             TM0,
  input  logic             START,
  input  logic [LEN_W-1:0] LEN,
  input  logic             DIN_VALID,
  input  logic [WIDTH-1:0] DIN,
  input  logic [WIDTH-1:0] SEED,
  input  logic [WIDTH-1:0] GOLDEN,
  input  logic             SCAN_IN,
  output logic [WIDTH-1:0] SIG,
  output logic             SCAN_OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS
);

  mode_e            w_mode;
  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_sig;
  logic [WIDTH-1:0] w_sig_nxt;
  logic [WIDTH-1:0] w_comp;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] w_cnt_nxt;
  logic             r_pass;
  logic             w_pass_nxt;

  assign w_mode = mode_e'({TM1, TM0});

  misr_next #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_next (
    .i_sig  (r_sig),
    .i_din  (DIN),
    .o_next (w_comp)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_IDLE;
      r_sig   <= '0;
      r_cnt   <= '0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sig   <= w_sig_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pass  <= w_pass_nxt;
    end
  end

  // Only NORMAL mode moves the FSM; the test modes touch the signature alone.
  always_comb begin
    w_state_nxt = r_state;
    w_sig_nxt   = r_sig;
    w_cnt_nxt   = r_cnt;
    w_pass_nxt  = r_pass;
    case (w_mode)
      MODE_NORMAL: begin
        case (r_state)
          ST_IDLE, ST_DONE: begin
            if (START) begin
              w_sig_nxt = SEED;
              w_cnt_nxt = LEN;
              if (LEN != '0) begin
                w_state_nxt = ST_RUN;
                w_pass_nxt  = 1'b0;
              end else begin
                w_state_nxt = ST_DONE;
                w_pass_nxt  = (SEED == GOLDEN);
              end
            end
          end
          ST_RUN: begin
            if (DIN_VALID) begin
              w_sig_nxt = w_comp;
              // Saturate at zero so the counter can never wrap.
              if (r_cnt <= LEN_W'(1)) begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_DONE;
                w_pass_nxt  = (w_comp == GOLDEN);
              end else begin
                w_cnt_nxt = r_cnt - LEN_W'(1);
              end
            end
          end
          default: w_state_nxt = ST_IDLE;
        endcase
      end
      MODE_SHIFT: w_sig_nxt = {r_sig[WIDTH-2:0], SCAN_IN};
      MODE_LOAD:  w_sig_nxt = SEED;
      default:    w_sig_nxt = r_sig;
    endcase
  end

  always_comb begin
    BUSY     = (r_state == ST_RUN);
    DONE     = (r_state == ST_DONE);
    PASS     = r_pass;
    SIG      = r_sig;
    SCAN_OUT = r_sig[WIDTH-1];
  end

endmodule

`default_nettype wire

// File: tb/tb_crc_misr_param.sv
// ============================================================================
// Module      : tb_crc_misr_param
// Description : Directed self-checking bench with a cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_crc_misr_param;

  localparam logic [31:0] c_poly = 32'h00010811;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        TM1 = 1'b0;
  logic        TM0 = 1'b0;
  logic        START = 1'b0;
  logic [15:0] LEN = '0;
  logic        DIN_VALID = 1'b0;
  logic [31:0] DIN = '0;
  logic [31:0] SEED = '0;
  logic [31:0] GOLDEN = '0;
  logic        SCAN_IN = 1'b0;
  logic [31:0] SIG;
  logic        SCAN_OUT;
  logic        BUSY;
  logic        DONE;
  logic        PASS;

  int lit_checks = 0;
  int lit_fails  = 0;
  int cyc_checks = 0;
  int cyc_fails  = 0;
  bit cmp_en     = 1'b0;

  crc_misr_param dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .TM1       (TM1),
    .TM0       (TM0),
    .START     (START),
    .LEN       (LEN),
    .DIN_VALID (DIN_VALID),
    .DIN       (DIN),
    .SEED      (SEED),
    .GOLDEN    (GOLDEN),
    .SCAN_IN   (SCAN_IN),
    .SIG       (SIG),
    .SCAN_OUT  (SCAN_OUT),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .PASS      (PASS)
  );

  always #5 CLK = ~CLK;

  // Polynomial division step written as shift-and-conditional-xor.
  function automatic logic [31:0] mstep(input logic [31:0] s, input logic [31:0] d);
    logic [31:0] r;
    r = (s << 1) ^ d;
    if (s[31]) r = r ^ (c_poly | 32'h1);
    return r;
  endfunction

  // Behavioural model: 0 = idle, 1 = running, 2 = done.
  logic [31:0] m_sig  = '0;
  int          m_left = 0;
  int          m_st   = 0;
  bit          m_pass = 1'b0;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_sig = '0; m_left = 0; m_st = 0; m_pass = 1'b0;
    end else begin
      case ({TM1, TM0})
        2'b00: begin
          if (m_st != 1 && START) begin
            m_sig  = SEED;
            m_left = int'(LEN);
            if (LEN == 0) begin m_st = 2; m_pass = (SEED == GOLDEN); end
            else          begin m_st = 1; m_pass = 1'b0; end
          end else if (m_st == 1 && DIN_VALID) begin
            m_sig  = mstep(m_sig, DIN);
            m_left = m_left - 1;
            if (m_left == 0) begin m_st = 2; m_pass = (m_sig == GOLDEN); end
          end
        end
        2'b10: m_sig = {m_sig[30:0], SCAN_IN};
        2'b11: m_sig = SEED;
        default: ;
      endcase
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      cyc_checks++;
      if (SIG !== m_sig || BUSY !== (m_st == 1) || DONE !== (m_st == 2) ||
          PASS !== m_pass || SCAN_OUT !== m_sig[31]) begin
        cyc_fails++;
        $display("FAIL cycle t=%0t sig=%h/%h busy=%b/%b done=%b/%b pass=%b/%b scan_out=%b/%b (actual/required)",
                 $time, SIG, m_sig, BUSY, (m_st == 1), DONE, (m_st == 2), PASS, m_pass, SCAN_OUT, m_sig[31]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    lit_checks++;
    if (act !== exp) begin
      lit_fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [31:0] pat;
    logic [31:0] e;
    logic [31:0] e1;
    logic [31:0] words [6];
    bit          vld   [6];
    int          n;

    // Pin the reference step itself.
    chk("model_step_a", mstep(32'h80000000, 32'h0), 32'h00010811);
    chk("model_step_b", mstep(32'h00000001, 32'h2), 32'h00000000);
    chk("model_step_c", mstep(32'h80000001, 32'h0), 32'h00010813);

    tick(); tick();
    cmp_en = 1'b1;
    chk("reset_sig", SIG, 32'h0);
    chk("reset_flags", {28'h0, BUSY, DONE, PASS, SCAN_OUT}, 32'h0);
    RESET = 1'b1;
    tick();

    // LOAD 0x80000000, one zero word, golden 0x00010811.
    {TM1, TM0} = 2'b11; SEED = 32'h80000000;
    tick();
    chk("load_sig", SIG, 32'h80000000);
    {TM1, TM0} = 2'b00; START = 1'b1; LEN = 16'd1; GOLDEN = 32'h00010811;
    tick();
    START = 1'b0;
    chk("one_word_busy", {31'h0, BUSY}, 32'h1);
    DIN_VALID = 1'b1; DIN = 32'h0;
    tick();
    DIN_VALID = 1'b0;
    chk("one_word_sig", SIG, 32'h00010811);
    chk("one_word_done_pass", {30'h0, DONE, PASS}, 32'h3);

    // Zero-length run.
    SEED = 32'h0; LEN = 16'd0; GOLDEN = 32'h0; START = 1'b1;
    tick();
    START = 1'b0;
    chk("zero_len_busy_done_pass", {29'h0, BUSY, DONE, PASS}, 32'h3);
    tick();
    chk("zero_len_busy_later", {31'h0, BUSY}, 32'h0);

    // LOAD A5A5A5A5 then shift out 32 bits.
    {TM1, TM0} = 2'b11; SEED = 32'hA5A5A5A5;
    tick();
    {TM1, TM0} = 2'b10; SCAN_IN = 1'b0;
    pat = 32'hA5A5A5A5;
    for (int k = 0; k < 32; k++) begin
      if (SCAN_OUT !== pat[31 - k]) begin
        lit_fails++;
        $display("FAIL scan_out_bit%0d actual=%b required=%b", k, SCAN_OUT, pat[31 - k]);
      end
      lit_checks++;
      tick();
    end
    chk("shift_final_sig", SIG, 32'h0);

    // Gapped run of four words.
    words[0] = 32'hDEADBEEF; words[1] = 32'h11111111; words[2] = 32'hCAFEF00D;
    words[3] = 32'h22222222; words[4] = 32'h0F0F0F0F; words[5] = 32'hFFFF0000;
    vld[0] = 1; vld[1] = 0; vld[2] = 1; vld[3] = 0; vld[4] = 1; vld[5] = 1;
    e = 32'h12345678;
    for (int i = 0; i < 6; i++) if (vld[i]) e = mstep(e, words[i]);
    {TM1, TM0} = 2'b00; SEED = 32'h12345678; LEN = 16'd4; GOLDEN = e; START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 6; i++) begin
      DIN_VALID = vld[i]; DIN = words[i];
      tick();
      if (i < 5) chk("gapped_not_done", {31'h0, DONE}, 32'h0);
    end
    DIN_VALID = 1'b0;
    chk("gapped_done_pass", {30'h0, DONE, PASS}, 32'h3);
    chk("gapped_sig", SIG, e);

    // HOLD mid-run, plus an ignored START while running.
    e1 = mstep(32'hA0A0A0A0, 32'h01234567);
    e  = mstep(mstep(e1, 32'h89ABCDEF), 32'h55AA55AA);
    SEED = 32'hA0A0A0A0; LEN = 16'd3; GOLDEN = e; START = 1'b1;
    tick();
    START = 1'b0; DIN_VALID = 1'b1; DIN = 32'h01234567;
    tick();
    {TM1, TM0} = 2'b01;
    for (int i = 0; i < 3; i++) begin
      DIN = (i % 2 == 0) ? 32'hFFFFFFFF : 32'h00000000;
      tick();
      chk("hold_sig", SIG, e1);
    end
    {TM1, TM0} = 2'b00; START = 1'b1; SEED = 32'h0BADF00D; DIN = 32'h89ABCDEF;
    tick();
    START = 1'b0; DIN = 32'h55AA55AA;
    tick();
    DIN_VALID = 1'b0;
    chk("hold_final_sig", SIG, e);
    chk("hold_done_pass", {30'h0, DONE, PASS}, 32'h3);

    // Asynchronous reset in the middle of a run.
    SEED = 32'h13579BDF; LEN = 16'd5; START = 1'b1;
    tick();
    START = 1'b0; DIN_VALID = 1'b1; DIN = 32'h24681357;
    tick(); tick();
    DIN_VALID = 1'b0;
    @(posedge CLK);
    #2 RESET = 1'b0;
    #1;
    chk("async_reset_sig", SIG, 32'h0);
    chk("async_reset_flags", {28'h0, BUSY, DONE, PASS, SCAN_OUT}, 32'h0);
    @(posedge CLK);
    #1 RESET = 1'b1;
    e = mstep(mstep(32'hFEEDFACE, 32'h33333333), 32'h44444444);
    SEED = 32'hFEEDFACE; LEN = 16'd2; GOLDEN = e; START = 1'b1;
    tick();
    START = 1'b0; DIN_VALID = 1'b1; DIN = 32'h33333333;
    tick();
    DIN = 32'h44444444;
    n = 0;
    do begin
      tick();
      DIN_VALID = 1'b0;
      n++;
    end while (!DONE && n < 10);
    chk("post_reset_run_done_pass", {30'h0, DONE, PASS}, 32'h3);
    chk("post_reset_run_sig", SIG, e);

    tick(); tick();
    cmp_en = 1'b0;
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", lit_checks + cyc_checks, lit_fails + cyc_fails);
    $finish;
  end

endmodule

`default_nettype wire
